morse_key_classifier: RTL and testbench
=======================================

Name: morse_key_classifier

Overview:
- Front end of the Morse path. Takes the raw, bouncy push-button key and turns it into single-cycle dot, dash, char_end and word_end pulses for the downstream Morse decoder.
- Contains a 2-FF synchronizer, a millisecond tick prescaler, a debouncer and a timing FSM that classifies press and gap durations.
- Also tracks elements per character and flags overflow beyond 5 elements, the decoder's limit.

Parameters:
- TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz)
- DEBOUNCE_T, 10, ticks the synchronized key must stay stable before the debounced level changes
- MIN_PRESS_T, 20, presses shorter than this many ticks are discarded as glitches
- DOT_MAX_T, 200, press < DOT_MAX_T ticks is a dot; >= is a dash
- CHAR_GAP_T, 400, release gap in ticks that ends a character
- WORD_GAP_T, 1000, release gap in ticks that ends a word (> CHAR_GAP_T)
- CNT_W, 12, width of the duration/gap counters; they saturate at 2^CNT_W-1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- key_in  in  1  raw key, asynchronous to clk, 1 = pressed
- dot  out  1  one-cycle pulse: dot element
- dash  out  1  one-cycle pulse: dash element
- char_end  out  1  one-cycle pulse: character complete
- word_end  out  1  one-cycle pulse: word gap elapsed
- key_level  out  1  debounced key level (for LED)
- elem_cnt  out  3  elements accepted in the current character, 0..5
- overflow  out  1  sticky: 6th or later element seen in the current character

Behaviour:
- Reset: reset is asynchronous, active-high, on signal rst; the clock is clk. All outputs, synchronizer, prescaler, counters go to 0; FSM goes to IDLE.
- Reset mid-press: the press is forgotten. If the key is still held after reset, it is detected as a new press once debounced.
- Synchronizer: 2 flops. Prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick when the count equals TICK_DIV-1.
- Debounce:
  - Counter clears whenever sync == key_level.
  - When they differ, the counter increments on each tick.
  - At DEBOUNCE_T the debouncer toggles key_level and clears the counter.
  - Rise and fall of key_level are edge-detected internally.
- FSM states: IDLE, PRESS, GAP, WORD_WAIT.
- IDLE:
  - On key_level rise: go to PRESS, dur = 0.
- PRESS: dur increments on each tick. On key_level fall:
  - dur < MIN_PRESS_T: no pulse. Return to IDLE if elem_cnt == 0, else GAP with gap = 0.
  - Otherwise, classify: dot if dur < DOT_MAX_T, else dash. Go to GAP with gap = 0.
    - If elem_cnt < 5: pulse dot/dash on the next clk and increment elem_cnt.
    - If elem_cnt == 5: no pulse, set overflow.
- GAP: gap increments on each tick.
  - Rise: go to PRESS, gap discarded.
  - gap reaches CHAR_GAP_T: pulse char_end, clear elem_cnt and overflow, go to WORD_WAIT with gap continuing.
- WORD_WAIT:
  - Rise: go to PRESS with no word_end.
  - gap reaches WORD_GAP_T: pulse word_end, go to IDLE.
- Rise and threshold in the same cycle: the rise wins; no char_end/word_end is emitted.
- Pulse rules:
  - All pulses are registered and exactly 1 clk wide.
  - At most one of dot/dash/char_end/word_end is high per cycle.
  - Consecutive pulses are always separated by at least one idle cycle, so the decoder's edge detector sees each one.
  - char_end is never emitted with elem_cnt == 0 unless overflow was set.
- Latency:
  - dot/dash: 1 clk after the key_level fall.
  - char_end/word_end: 1 clk after the threshold tick.
  - key_level: DEBOUNCE_T ticks plus up to 2 clk after a stable raw change.
- Saturation: dur and gap saturate, never wrap. A dash held arbitrarily long still classifies as a dash.

Test Plan:
(Bench parameters: TICK_DIV=4, DEBOUNCE_T=2, MIN_PRESS_T=3, DOT_MAX_T=10, CHAR_GAP_T=20, WORD_GAP_T=50.)
- Clean 5-tick press, then silence -> one dot pulse and elem_cnt=1; char_end 20 ticks after release with elem_cnt back to 0; word_end at 50 ticks; FSM in IDLE.
- 15-tick press -> one dash pulse (no dot). A press held 5000 ticks -> still exactly one dash (saturation check).
- key_in toggling every clk for 6 clk (shorter than one debounce) -> key_level stays 0 and no pulses.
- 2-tick debounced press -> no dot/dash and elem_cnt unchanged. Separately, a new press at gap=19 -> no char_end, and the next element increments elem_cnt to 2.
- Six 5-tick dots with 5-tick gaps -> exactly 5 dot pulses, elem_cnt=5, overflow=1 after the 6th; char_end clears overflow and elem_cnt to 0.
- rst asserted mid-press at dur=8, released with the key still held -> all outputs 0 during reset; after release, no pulse until a debounced fall; key_level re-rises after 2 ticks.

Source files
------------

// File: rtl/morse_key_classifier.sv
// Morse key front end: synchronizes and debounces the raw key, then times
// presses and gaps to emit single-cycle dot/dash/char_end/word_end pulses.
module morse_key_classifier #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned DEBOUNCE_T  = 10,
  parameter int unsigned MIN_PRESS_T = 20,
  parameter int unsigned DOT_MAX_T   = 200,
  parameter int unsigned CHAR_GAP_T  = 400,
  parameter int unsigned WORD_GAP_T  = 1000,
  parameter int unsigned CNT_W       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       dot,
  output logic       dash,
  output logic       char_end,
  output logic       word_end,
  output logic       key_level,
  output logic [2:0] elem_cnt,
  output logic       overflow
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_T + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       ELEM_MAX = 3'd5;

  typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD_WAIT} state_t;

  logic             sync1_q, sync2_q;
  logic [PW-1:0]    presc_q;
  logic [DW-1:0]    db_cnt_q;
  logic             key_level_q, key_prev_q;
  logic             tick_c, rise_c, fall_c;
  logic [CNT_W-1:0] dur_inc_c, gap_inc_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d, gap_q, gap_d;
  logic [2:0]       elem_cnt_q, elem_cnt_d;
  logic             overflow_q, overflow_d;
  logic             dot_q, dot_d, dash_q, dash_d;
  logic             char_end_q, char_end_d, word_end_q, word_end_d;

  assign tick_c    = (presc_q == PW'(TICK_DIV - 1));
  assign rise_c    = key_level_q & ~key_prev_q;
  assign fall_c    = ~key_level_q & key_prev_q;
  assign dur_inc_c = (dur_q == CNT_MAX) ? dur_q : dur_q + CNT_W'(1);
  assign gap_inc_c = (gap_q == CNT_MAX) ? gap_q : gap_q + CNT_W'(1);

  // Two-flop synchronizer for the asynchronous key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Timing tick prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick_c ? '0 : presc_q + PW'(1);
    end
  end

  // Debouncer: level flips only after DEBOUNCE_T ticks of continuous disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q    <= '0;
      key_level_q <= 1'b0;
      key_prev_q  <= 1'b0;
    end else begin
      key_prev_q <= key_level_q;
      if (sync2_q == key_level_q) begin
        db_cnt_q <= '0;
      end else if (tick_c) begin
        if (db_cnt_q == DW'(DEBOUNCE_T - 1)) begin
          key_level_q <= ~key_level_q;
          db_cnt_q    <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DW'(1);
        end
      end
    end
  end

  // Classifier state and registered pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dur_q      <= '0;
      gap_q      <= '0;
      elem_cnt_q <= '0;
      overflow_q <= 1'b0;
      dot_q      <= 1'b0;
      dash_q     <= 1'b0;
      char_end_q <= 1'b0;
      word_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      elem_cnt_q <= elem_cnt_d;
      overflow_q <= overflow_d;
      dot_q      <= dot_d;
      dash_q     <= dash_d;
      char_end_q <= char_end_d;
      word_end_q <= word_end_d;
    end
  end

  // Next-state: time presses and gaps; a rise always beats a gap threshold
  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    elem_cnt_d = elem_cnt_q;
    overflow_d = overflow_q;
    dot_d      = 1'b0;
    dash_d     = 1'b0;
    char_end_d = 1'b0;
    word_end_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d = PRESS;
          dur_d   = '0;
        end
      end
      PRESS: begin
        if (fall_c) begin
          gap_d = '0;
          if (dur_q < CNT_W'(MIN_PRESS_T)) begin
            state_d = (elem_cnt_q == 3'd0) ? IDLE : GAP;
          end else begin
            state_d = GAP;
            if (elem_cnt_q < ELEM_MAX) begin
              dot_d      = (dur_q < CNT_W'(DOT_MAX_T));
              dash_d     = ~(dur_q < CNT_W'(DOT_MAX_T));
              elem_cnt_d = elem_cnt_q + 3'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else if (tick_c) begin
          dur_d = dur_inc_c;
        end
      end
      GAP: begin
        if (rise_c) begin
          state_d = PRESS;
          dur_d   = '0;
        end else if (tick_c) begin
          gap_d = gap_inc_c;
          if (gap_inc_c >= CNT_W'(CHAR_GAP_T)) begin
            char_end_d = 1'b1;
            elem_cnt_d = '0;
            overflow_d = 1'b0;
            state_d    = WORD_WAIT;
          end
        end
      end
      WORD_WAIT: begin
        if (rise_c) begin
          state_d = PRESS;
          dur_d   = '0;
        end else if (tick_c) begin
          gap_d = gap_inc_c;
          if (gap_inc_c >= CNT_W'(WORD_GAP_T)) begin
            word_end_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dot       = dot_q;
  assign dash      = dash_q;
  assign char_end  = char_end_q;
  assign word_end  = word_end_q;
  assign key_level = key_level_q;
  assign elem_cnt  = elem_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Scoreboard bench for morse_key_classifier: expected pulses are queued as
// stimulus is driven and popped when the DUT pulses.
module tb_morse_key_classifier;

  localparam int unsigned TD   = 4;
  localparam int unsigned CHAR = 20;
  localparam int unsigned WORD = 50;
  localparam int K_DOT = 1, K_DASH = 2, K_CHR = 3, K_WRD = 4;

  logic       clk, rst, key_in;
  logic       dot, dash, char_end, word_end, key_level, overflow;
  logic [2:0] elem_cnt;

  typedef struct packed {
    logic [2:0] kind;
    logic [2:0] elem;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors, miscompares;
  int   cyc, fall_cyc;

  morse_key_classifier #(
    .TICK_DIV(TD), .DEBOUNCE_T(2), .MIN_PRESS_T(3), .DOT_MAX_T(10),
    .CHAR_GAP_T(CHAR), .WORD_GAP_T(WORD), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .dot(dot), .dash(dash), .char_end(char_end), .word_end(word_end),
    .key_level(key_level), .elem_cnt(elem_cnt), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input int elem, input int ovf);
    exp_t e;
    e.kind = 3'(kind);
    e.elem = 3'(elem);
    e.ovf  = 1'(ovf);
    exp_q.push_back(e);
  endtask

  // Returns 1 time unit after a rising edge
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    wait_clk(n * TD);
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    wait_ticks(n);
    key_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    wait_ticks(WORD + 20);
    check_eq(tag, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every pulse and checks shape and latency
  task automatic mon_loop();
    logic prev_any, lvl_prev;
    int   obs, d;
    exp_t e;
    prev_any = 1'b0;
    lvl_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_any = 1'b0;
        lvl_prev = 1'b0;
      end else begin
        if (lvl_prev && !key_level) fall_cyc = cyc;
        lvl_prev = key_level;
        if (dot | dash | char_end | word_end) begin
          obs = dot ? K_DOT : dash ? K_DASH : char_end ? K_CHR : K_WRD;
          check_eq("onehot", $countones({dot, dash, char_end, word_end}), 1);
          check_eq("pulse_spacing", int'(prev_any), 0);
          if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", obs, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("pulse_kind", obs, int'(e.kind));
            check_eq("pulse_elem_cnt", int'(elem_cnt), int'(e.elem));
            check_eq("pulse_overflow", int'(overflow), int'(e.ovf));
            d = cyc - fall_cyc;
            if (obs == K_CHR)
              check_eq("char_latency_ok", int'(d >= int'(TD*CHAR) - 4 && d <= int'(TD*CHAR) + 4), 1);
            if (obs == K_WRD)
              check_eq("word_latency_ok", int'(d >= int'(TD*WORD) - 4 && d <= int'(TD*WORD) + 4), 1);
          end
          prev_any = 1'b1;
        end else begin
          prev_any = 1'b0;
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    fall_cyc    = 0;
    key_in      = 1'b0;
    rst         = 1'b1;
    fork
      mon_loop();
    join_none

    // Reset state
    wait_clk(3);
    check_eq("reset_outputs", int'({dot, dash, char_end, word_end, key_level, overflow, elem_cnt}), 0);
    rst = 1'b0;
    wait_clk(2);

    // Clean dot, then silence through char and word gaps
    push(K_DOT, 1, 0); push(K_CHR, 0, 0); push(K_WRD, 0, 0);
    press(5);
    drain("drain_dot");
    check_eq("idle_after_word", int'(dut.state_q), 0);

    // Dash
    push(K_DASH, 1, 0); push(K_CHR, 0, 0); push(K_WRD, 0, 0);
    press(15);
    drain("drain_dash");

    // Very long press saturates and stays a dash
    push(K_DASH, 1, 0); push(K_CHR, 0, 0); push(K_WRD, 0, 0);
    press(5000);
    drain("drain_long_dash");

    // Bounce faster than one debounce interval
    for (int i = 0; i < 6; i++) begin
      key_in = ~key_in;
      wait_clk(1);
      check_eq("bounce_level", int'(key_level), 0);
    end
    key_in = 1'b0;
    wait_ticks(10);
    check_eq("bounce_level_end", int'(key_level), 0);
    check_eq("drain_bounce", exp_q.size(), 0);

    // Glitch press from idle is discarded
    press(2);
    wait_ticks(10);
    check_eq("glitch_idle_elem", int'(elem_cnt), 0);
    check_eq("glitch_idle_state", int'(dut.state_q), 0);

    // Glitch inside a character, then a press at gap=19 continues the character
    push(K_DOT, 1, 0);
    press(5);
    wait_ticks(5);
    press(2);
    wait_ticks(5);
    check_eq("glitch_gap_elem", int'(elem_cnt), 1);
    wait_ticks(14);
    push(K_DOT, 2, 0);
    press(5);
    push(K_CHR, 0, 0); push(K_WRD, 0, 0);
    drain("drain_gap19");

    // Six dots: fifth is the last pulse, sixth sets overflow
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) push(K_DOT, i, 0);
      press(5);
      wait_ticks(5);
    end
    check_eq("ovf_elem_cnt", int'(elem_cnt), 5);
    check_eq("ovf_flag", int'(overflow), 1);
    push(K_CHR, 0, 0); push(K_WRD, 0, 0);
    drain("drain_overflow");
    check_eq("ovf_cleared", int'(overflow), 0);
    check_eq("ovf_elem_cleared", int'(elem_cnt), 0);

    // Reset mid-press with the key still held
    key_in = 1'b1;
    wait_ticks(10);
    rst = 1'b1;
    wait_clk(3);
    check_eq("midpress_reset_outputs", int'({dot, dash, char_end, word_end, key_level, overflow, elem_cnt}), 0);
    rst = 1'b0;
    check_eq("post_reset_level", int'(key_level), 0);
    wait_ticks(3);
    check_eq("post_reset_rerise", int'(key_level), 1);
    wait_ticks(5);
    push(K_DOT, 1, 0); push(K_CHR, 0, 0); push(K_WRD, 0, 0);
    key_in = 1'b0;
    drain("drain_reset_press");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
